// File: rtl/alu_writeback.sv
// alu_writeback
// Retire stage that sits directly after the ALU. It takes one result bundle
// at a time and writes it into a single-write-port register file. R always
// goes to dest, and when asked S goes to SREG_ADDR one cycle later. A faulting
// bundle writes nothing. Instead it latches PC and cause until the control
// unit clears them.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   bundle handshake; accept = in_valid & in_ready
//   alu_r, alu_s          primary / secondary ALU results
//   alu_exc, alu_ctl      exception flag and control code of the operation
//   dest, wr_s, pc        R destination, write-S request, operation PC
//   rf_we/waddr/wdata     registered register-file write port
//   exc_flag/pc/cause     latched exception state
//   exc_clr               exception acknowledge from the control unit
//   retired               wrapping count of non-faulting bundles retired
module alu_writeback #(
    parameter int              DW        = 16,
    parameter int              AW        = 4,
    parameter logic [AW-1:0]   SREG_ADDR = 4'hF,
    parameter int              CW        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_r,
    input  logic [DW-1:0] alu_s,
    input  logic          alu_exc,
    input  logic [CW-1:0] alu_ctl,
    input  logic [AW-1:0] dest,
    input  logic          wr_s,
    input  logic [DW-1:0] pc,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          exc_flag,
    output logic [DW-1:0] exc_pc,
    output logic [CW-1:0] exc_cause,
    input  logic          exc_clr,
    output logic [15:0]   retired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_R = 2'd1,
        ST_WR_S = 2'd2,
        ST_EXC  = 2'd3
    } state_t;

    state_t        state_r, state_next_s;
    logic          rf_we_r, rf_we_next_s;
    logic [AW-1:0] rf_waddr_r, rf_waddr_next_s;
    logic [DW-1:0] rf_wdata_r, rf_wdata_next_s;
    logic          exc_flag_r, exc_flag_next_s;
    logic [DW-1:0] exc_pc_r, exc_pc_next_s;
    logic [CW-1:0] exc_cause_r, exc_cause_next_s;
    logic [15:0]   retired_r, retired_next_s;
    logic [DW-1:0] hold_s_r, hold_s_next_s;
    logic          hold_wr_s_r, hold_wr_s_next_s;
    logic          in_ready_s;
    logic          accept_s;

    // A new bundle is taken only when idle with no exception outstanding.
    assign in_ready_s = (state_r == ST_IDLE) && !exc_flag_r;
    assign accept_s   = in_valid && in_ready_s;

    // Next-state and next-output logic. The write-port registers are loaded
    // on the edge that enters each write state, so the write shows up during
    // that state's cycle.
    always_comb begin
        state_next_s     = state_r;
        rf_we_next_s     = 1'b0;
        rf_waddr_next_s  = rf_waddr_r;
        rf_wdata_next_s  = rf_wdata_r;
        exc_flag_next_s  = exc_flag_r;
        exc_pc_next_s    = exc_pc_r;
        exc_cause_next_s = exc_cause_r;
        retired_next_s   = retired_r;
        hold_s_next_s    = hold_s_r;
        hold_wr_s_next_s = hold_wr_s_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (alu_exc) begin
                        state_next_s     = ST_EXC;
                        exc_flag_next_s  = 1'b1;
                        exc_pc_next_s    = pc;
                        exc_cause_next_s = alu_ctl;
                    end else begin
                        state_next_s     = ST_WR_R;
                        // r0 is hardwired: the slot is spent but nothing is written
                        rf_we_next_s     = (dest != {AW{1'b0}});
                        rf_waddr_next_s  = dest;
                        rf_wdata_next_s  = alu_r;
                        hold_s_next_s    = alu_s;
                        hold_wr_s_next_s = wr_s;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_R: begin
                if (hold_wr_s_r) begin
                    state_next_s    = ST_WR_S;
                    rf_we_next_s    = 1'b1;
                    rf_waddr_next_s = SREG_ADDR;
                    rf_wdata_next_s = hold_s_r;
                end else begin
                    state_next_s   = ST_IDLE;
                    retired_next_s = retired_r + 16'd1;
                end
            end
            ST_WR_S: begin
                state_next_s   = ST_IDLE;
                retired_next_s = retired_r + 16'd1;
            end
            ST_EXC: begin
                if (exc_clr) begin
                    state_next_s    = ST_IDLE;
                    exc_flag_next_s = 1'b0;
                end else begin
                    state_next_s = ST_EXC;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, output, and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rf_we_r     <= 1'b0;
            rf_waddr_r  <= {AW{1'b0}};
            rf_wdata_r  <= {DW{1'b0}};
            exc_flag_r  <= 1'b0;
            exc_pc_r    <= {DW{1'b0}};
            exc_cause_r <= {CW{1'b0}};
            retired_r   <= 16'd0;
            hold_s_r    <= {DW{1'b0}};
            hold_wr_s_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rf_we_r     <= rf_we_next_s;
            rf_waddr_r  <= rf_waddr_next_s;
            rf_wdata_r  <= rf_wdata_next_s;
            exc_flag_r  <= exc_flag_next_s;
            exc_pc_r    <= exc_pc_next_s;
            exc_cause_r <= exc_cause_next_s;
            retired_r   <= retired_next_s;
            hold_s_r    <= hold_s_next_s;
            hold_wr_s_r <= hold_wr_s_next_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign rf_we     = rf_we_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign exc_flag  = exc_flag_r;
    assign exc_pc    = exc_pc_r;
    assign exc_cause = exc_cause_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback. It uses directed scenarios and then
// random bundles. Expected values come from a transaction-level model that
// holds the retire count and the last register-file address and data.
module tb_alu_writeback;

    localparam logic [3:0] SREG = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_r;
    logic [15:0] alu_s;
    logic        alu_exc;
    logic [3:0]  alu_ctl;
    logic [3:0]  dest;
    logic        wr_s;
    logic [15:0] pc;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        exc_flag;
    logic [15:0] exc_pc;
    logic [3:0]  exc_cause;
    logic        exc_clr;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [15:0] m_retired;
    logic [3:0]  m_waddr;
    logic [15:0] m_wdata;

    alu_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_r     (alu_r),
        .alu_s     (alu_s),
        .alu_exc   (alu_exc),
        .alu_ctl   (alu_ctl),
        .dest      (dest),
        .wr_s      (wr_s),
        .pc        (pc),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .exc_flag  (exc_flag),
        .exc_pc    (exc_pc),
        .exc_cause (exc_cause),
        .exc_clr   (exc_clr),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one bundle, which must be accepted on the next edge, and follow
    // it through until the stage is idle again.
    task automatic do_bundle(input logic [15:0] r, input logic [15:0] s, input logic exc,
                             input logic [3:0] ctl, input logic [3:0] d, input logic ws,
                             input logic [15:0] p);
        in_valid = 1'b1;
        alu_r = r; alu_s = s; alu_exc = exc; alu_ctl = ctl; dest = d; wr_s = ws; pc = p;
        chk("ready_before_accept", in_ready, 1);
        step();
        if (exc) begin
            chk("exc_no_we", rf_we, 0);
            chk("exc_flag_set", exc_flag, 1);
            chk("exc_pc", exc_pc, p);
            chk("exc_cause", exc_cause, ctl);
            chk("exc_ready", in_ready, 0);
            chk("exc_retired", retired, m_retired);
            for (int i = 0; i < 3; i++) begin
                step();
                chk("exc_stall_ready", in_ready, 0);
                chk("exc_stall_we", rf_we, 0);
                chk("exc_stall_flag", exc_flag, 1);
            end
            exc_clr = 1'b1;
            step();
            exc_clr = 1'b0;
            chk("clr_flag", exc_flag, 0);
            chk("clr_ready", in_ready, 1);
            chk("clr_retired", retired, m_retired);
            chk("clr_waddr_hold", rf_waddr, m_waddr);
            chk("clr_wdata_hold", rf_wdata, m_wdata);
        end else begin
            // an acknowledge with no exception pending must be ignored
            exc_clr = 1'($urandom_range(0, 1));
            chk("r_we", rf_we, (d != 4'd0));
            chk("r_waddr", rf_waddr, d);
            chk("r_wdata", rf_wdata, r);
            chk("r_ready", in_ready, 0);
            m_waddr = d;
            m_wdata = r;
            if (ws) begin
                step();
                chk("s_we", rf_we, 1);
                chk("s_waddr", rf_waddr, SREG);
                chk("s_wdata", rf_wdata, s);
                chk("s_ready", in_ready, 0);
                m_waddr = SREG;
                m_wdata = s;
            end
            m_retired = m_retired + 16'd1;
            step();
            exc_clr = 1'b0;
            chk("done_we", rf_we, 0);
            chk("done_waddr_hold", rf_waddr, m_waddr);
            chk("done_wdata_hold", rf_wdata, m_wdata);
            chk("done_ready", in_ready, 1);
            chk("done_retired", retired, m_retired);
            chk("done_no_exc", exc_flag, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; exc_clr = 1'b0;
        alu_r = 16'd0; alu_s = 16'd0; alu_exc = 1'b0; alu_ctl = 4'd0;
        dest = 4'd0; wr_s = 1'b0; pc = 16'd0;
        m_retired = 16'd0; m_waddr = 4'd0; m_wdata = 16'd0;
        #3;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_exc_flag", exc_flag, 0);
        chk("rst_exc_pc", exc_pc, 0);
        chk("rst_exc_cause", exc_cause, 0);
        chk("rst_retired", retired, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", in_ready, 1);

        // single write, dual write, exception, r0 suppression
        do_bundle(16'h0002, 16'h0000, 1'b0, 4'd0, 4'd5, 1'b0, 16'h0000);
        do_bundle(16'h0001, 16'hFFFF, 1'b0, 4'd0, 4'd2, 1'b1, 16'h0000);
        do_bundle(16'h0000, 16'h0000, 1'b1, 4'b0010, 4'd7, 1'b0, 16'h0040);
        do_bundle(16'hABCD, 16'h1234, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000);
        // S-register as dest: S must land last
        do_bundle(16'h1111, 16'h2222, 1'b0, 4'd0, 4'hF, 1'b1, 16'h0000);

        // back-to-back with in_valid held high
        do_bundle(16'h0101, 16'h0000, 1'b0, 4'd0, 4'd1, 1'b0, 16'h0000);
        do_bundle(16'h0202, 16'h0000, 1'b0, 4'd0, 4'd3, 1'b0, 16'h0000);
        do_bundle(16'h0303, 16'h0000, 1'b0, 4'd0, 4'd4, 1'b0, 16'h0000);

        // asynchronous reset in the middle of WR_S
        in_valid = 1'b1;
        alu_r = 16'h5555; alu_s = 16'h6666; alu_exc = 1'b0; dest = 4'd3; wr_s = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mid_wr_r_we", rf_we, 1);
        step();
        chk("mid_wr_s_we", rf_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_waddr", rf_waddr, 0);
        chk("async_rst_wdata", rf_wdata, 0);
        chk("async_rst_retired", retired, 0);
        chk("async_rst_flag", exc_flag, 0);
        #2;
        rst_n = 1'b1;
        m_retired = 16'd0; m_waddr = 4'd0; m_wdata = 16'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_rst_ready", in_ready, 1);
            chk("after_rst_no_we", rf_we, 0);
            chk("after_rst_retired", retired, 0);
        end

        // randomized bundles
        for (int i = 0; i < 40; i++) begin
            do_bundle(16'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0),
                      4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        // retire-counter wrap
        in_valid = 1'b0;
        step();
        force dut.retired_r = 16'hFFFF;
        step();
        release dut.retired_r;
        step();
        chk("preload_retired", retired, 16'hFFFF);
        m_retired = 16'hFFFF;
        do_bundle(16'h7777, 16'h0000, 1'b0, 4'd9, 4'd6, 1'b0, 16'h0000);
        chk("wrap_retired_zero", retired, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
